// File: rtl/audio_sample_fifo_sc.sv
// Single-clock audio sample FIFO with prefill gate, selectable overflow policy,
// occupancy/threshold flags and sticky error flags; unserved reads return NULL_VALUE.
module audio_sample_fifo_sc #(
    parameter int unsigned              DATA_WIDTH = 8,
    parameter int unsigned              ADDR_WIDTH = 9,
    parameter logic [DATA_WIDTH-1:0]    NULL_VALUE = DATA_WIDTH'(8'h80),
    parameter int unsigned              PREFILL    = 256,
    parameter int unsigned              AFULL_THR  = 448,
    parameter int unsigned              AEMPTY_THR = 64,
    parameter int unsigned              OVF_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  we_i,
    input  logic                  re_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  valid_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  aempty_o,
    output logic                  afull_o,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  primed_o,
    output logic                  ovf_o,
    output logic                  unf_o,
    input  logic                  clr_flags_i
);

    localparam int unsigned      DEPTH      = 1 << ADDR_WIDTH;
    localparam int unsigned      LVL_W      = ADDR_WIDTH + 1;
    localparam logic [LVL_W-1:0] LVL_DEPTH  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_PRE    = LVL_W'(PREFILL);
    localparam logic [LVL_W-1:0] LVL_AFULL  = LVL_W'(AFULL_THR);
    localparam logic [LVL_W-1:0] LVL_AEMPTY = LVL_W'(AEMPTY_THR);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   r_wptr;
    logic [ADDR_WIDTH-1:0]   r_rptr;
    logic [LVL_W-1:0]        r_level;
    logic [DATA_WIDTH-1:0]   r_dat;
    logic                    r_valid;
    logic                    r_empty;
    logic                    r_full;
    logic                    r_aempty;
    logic                    r_afull;
    logic                    r_ovf;
    logic                    r_unf;

    logic                    w_full_now;
    logic                    w_rd_acc;
    logic                    w_underrun;
    logic                    w_wr_store;
    logic                    w_ovr;
    logic                    w_ovf_ev;
    logic                    w_lvl_inc;
    logic [LVL_W-1:0]        w_level_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_FILL;
        end else if (flush_i) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus read/write acceptance; FILL gates reads until the prefill level is seen.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_acc    = 1'b0;
        w_underrun  = 1'b0;
        w_wr_store  = 1'b0;
        w_ovr       = 1'b0;
        w_ovf_ev    = 1'b0;
        w_full_now  = (r_level == LVL_DEPTH);

        case (r_state)
            ST_FILL: begin
                if (r_level >= LVL_PRE) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (re_i) begin
                    if (r_level != '0) begin
                        w_rd_acc = 1'b1;
                    end else begin
                        w_underrun  = 1'b1;
                        w_state_nxt = ST_FILL;
                    end
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase

        if (we_i) begin
            if (!w_full_now || w_rd_acc) begin
                w_wr_store = 1'b1;
            end else begin
                w_ovf_ev = 1'b1;
                if (OVF_MODE != 0) begin
                    w_wr_store = 1'b1;
                    w_ovr      = 1'b1;
                end
            end
        end

        w_lvl_inc   = w_wr_store && !w_ovr;
        w_level_nxt = r_level + LVL_W'(w_lvl_inc) - LVL_W'(w_rd_acc);
    end

    always_ff @(posedge clk) begin
        if (rst && !flush_i && w_wr_store) begin
            r_mem[r_wptr] <= dat_i;
        end
    end

    // Pointers, occupancy, flags and the registered read port.
    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_dat    <= NULL_VALUE;
            r_valid  <= 1'b0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_aempty <= 1'b1;
            r_afull  <= 1'b0;
        end else begin
            if (w_wr_store) begin
                r_wptr <= r_wptr + ADDR_WIDTH'(1);
            end
            if (w_rd_acc || w_ovr) begin
                r_rptr <= r_rptr + ADDR_WIDTH'(1);
            end
            if (w_rd_acc) begin
                r_dat   <= r_mem[r_rptr];
                r_valid <= 1'b1;
            end else begin
                if (re_i) begin
                    r_dat <= NULL_VALUE;
                end
                r_valid <= 1'b0;
            end
            r_level  <= w_level_nxt;
            r_empty  <= (w_level_nxt == '0);
            r_full   <= (w_level_nxt == LVL_DEPTH);
            r_aempty <= (w_level_nxt <= LVL_AEMPTY);
            r_afull  <= (w_level_nxt >= LVL_AFULL);
        end
    end

    // Sticky error flags survive flush; a new event beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (!flush_i) begin
            r_ovf <= w_ovf_ev   | (r_ovf & ~clr_flags_i);
            r_unf <= w_underrun | (r_unf & ~clr_flags_i);
        end
    end

    assign dat_o    = r_dat;
    assign valid_o  = r_valid;
    assign empty_o  = r_empty;
    assign full_o   = r_full;
    assign aempty_o = r_aempty;
    assign afull_o  = r_afull;
    assign level_o  = r_level;
    assign primed_o = (r_state == ST_RUN);
    assign ovf_o    = r_ovf;
    assign unf_o    = r_unf;

endmodule

// File: tb/tb_audio_sample_fifo_sc.sv
// Bench for audio_sample_fifo_sc: drop-mode and overwrite-mode instances share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_audio_sample_fifo_sc;

    localparam int DEPTH   = 512;
    localparam int PREFILL = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush_i;
    logic [7:0] dat_i;
    logic       we_i;
    logic       re_i;
    logic       clr_flags_i;

    logic [7:0] d0_dat, d1_dat;
    logic       d0_valid, d0_empty, d0_full, d0_aempty, d0_afull, d0_primed, d0_ovf, d0_unf;
    logic       d1_valid, d1_empty, d1_full, d1_aempty, d1_afull, d1_primed, d1_ovf, d1_unf;
    logic [9:0] d0_level, d1_level;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    audio_sample_fifo_sc #(.OVF_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .flush_i(flush_i), .dat_i(dat_i), .we_i(we_i), .re_i(re_i),
        .dat_o(d0_dat), .valid_o(d0_valid), .empty_o(d0_empty), .full_o(d0_full),
        .aempty_o(d0_aempty), .afull_o(d0_afull), .level_o(d0_level), .primed_o(d0_primed),
        .ovf_o(d0_ovf), .unf_o(d0_unf), .clr_flags_i(clr_flags_i)
    );

    audio_sample_fifo_sc #(.OVF_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .flush_i(flush_i), .dat_i(dat_i), .we_i(we_i), .re_i(re_i),
        .dat_o(d1_dat), .valid_o(d1_valid), .empty_o(d1_empty), .full_o(d1_full),
        .aempty_o(d1_aempty), .afull_o(d1_afull), .level_o(d1_level), .primed_o(d1_primed),
        .ovf_o(d1_ovf), .unf_o(d1_unf), .clr_flags_i(clr_flags_i)
    );

    // Reference model: one sample queue per overflow policy.
    byte unsigned q0[$];
    byte unsigned q1[$];
    bit           m_primed [2];
    bit           m_ovf    [2];
    bit           m_unf    [2];
    logic [7:0]   m_dat    [2];
    bit           m_valid  [2];

    function automatic int q_size(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    task automatic q_clear(input int m);
        if (m == 0) q0.delete(); else q1.delete();
    endtask

    task automatic q_push(input int m, input byte unsigned d);
        if (m == 0) q0.push_back(d); else q1.push_back(d);
    endtask

    task automatic q_pop(input int m, output byte unsigned d);
        if (m == 0) d = q0.pop_front(); else d = q1.pop_front();
    endtask

    task automatic model_step(input int m);
        int           lvl;
        bit           rd, und, oe, np;
        byte unsigned d;
        lvl = q_size(m);
        rd  = 1'b0;
        und = 1'b0;
        oe  = 1'b0;
        np  = m_primed[m];
        if (!rst) begin
            q_clear(m);
            m_primed[m] = 1'b0;
            m_ovf[m]    = 1'b0;
            m_unf[m]    = 1'b0;
            m_dat[m]    = 8'h80;
            m_valid[m]  = 1'b0;
        end else if (flush_i) begin
            q_clear(m);
            m_primed[m] = 1'b0;
            m_dat[m]    = 8'h80;
            m_valid[m]  = 1'b0;
        end else begin
            if (!m_primed[m]) begin
                np = (lvl >= PREFILL);
            end else if (re_i) begin
                if (lvl > 0) rd = 1'b1;
                else begin
                    und = 1'b1;
                    np  = 1'b0;
                end
            end
            if (rd) begin
                q_pop(m, d);
                m_dat[m]   = d;
                m_valid[m] = 1'b1;
            end else begin
                if (re_i) m_dat[m] = 8'h80;
                m_valid[m] = 1'b0;
            end
            if (we_i) begin
                if (lvl < DEPTH || rd) q_push(m, dat_i);
                else begin
                    oe = 1'b1;
                    if (m == 1) begin
                        q_pop(m, d);
                        q_push(m, dat_i);
                    end
                end
            end
            m_ovf[m]    = oe  || (m_ovf[m] && !clr_flags_i);
            m_unf[m]    = und || (m_unf[m] && !clr_flags_i);
            m_primed[m] = np;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    function automatic logic [25:0] exp_vec(input int m);
        int n;
        n = q_size(m);
        return {m_dat[m], m_valid[m], (n == 0), (n == DEPTH), (n <= 64), (n >= 448),
                10'(n), m_primed[m], m_ovf[m], m_unf[m]};
    endfunction

    function automatic logic [25:0] obs_vec(input int m);
        if (m == 0)
            return {d0_dat, d0_valid, d0_empty, d0_full, d0_aempty, d0_afull,
                    d0_level, d0_primed, d0_ovf, d0_unf};
        return {d1_dat, d1_valid, d1_empty, d1_full, d1_aempty, d1_afull,
                d1_level, d1_primed, d1_ovf, d1_unf};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush_i     = 1'b0;
        we_i        = 1'b0;
        re_i        = 1'b0;
        clr_flags_i = 1'b0;
        dat_i       = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        for (int m = 0; m < 2; m++) begin
            n_tests++;
            if (obs_vec(m) !== exp_vec(m)) begin
                n_fail++;
                $display("FAIL reset_model dut%0d got %h expected %h", m, obs_vec(m), exp_vec(m));
            end
        end
        n_tests++;
        if (d0_dat !== 8'h80 || d0_level !== 10'd0 || d0_empty !== 1'b1 || d0_primed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values got dat=%h lvl=%0d empty=%b primed=%b expected 80/0/1/0",
                     d0_dat, d0_level, d0_empty, d0_primed);
        end
        rst = 1'b1;
    endtask

    task automatic test_prefill();
        for (int i = 0; i < 256; i++) begin
            we_i  = 1'b1;
            dat_i = 8'(i);
            tick();
            n_tests++;
            if (obs_vec(0) !== exp_vec(0) || d0_valid !== 1'b0 || d0_dat !== 8'h80) begin
                n_fail++;
                $display("FAIL prefill idx %0d got %h expected %h", i, obs_vec(0), exp_vec(0));
            end
        end
        we_i = 1'b0;
        n_tests++;
        if (d0_level !== 10'd256 || d0_primed !== 1'b0) begin
            n_fail++;
            $display("FAIL prefill_level got lvl=%0d primed=%b expected 256/0", d0_level, d0_primed);
        end
        tick();
        n_tests++;
        if (d0_primed !== 1'b1 || d1_primed !== 1'b1 || d0_valid !== 1'b0 || d0_dat !== 8'h80) begin
            n_fail++;
            $display("FAIL prefill_primed got primed=%b/%b valid=%b dat=%h expected 1/1/0/80",
                     d0_primed, d1_primed, d0_valid, d0_dat);
        end
    endtask

    task automatic test_ordered_read();
        for (int i = 0; i < 256; i++) begin
            re_i = 1'b1;
            tick();
            re_i = 1'b0;
            n_tests++;
            if (d0_dat !== 8'(i) || d0_valid !== 1'b1 || obs_vec(1) !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL ordered_read idx %0d got %h/%b expected %h/1", i, d0_dat, d0_valid, 8'(i));
            end
            if ($urandom_range(0, 1) == 1) begin
                tick();
                n_tests++;
                if (obs_vec(0) !== exp_vec(0)) begin
                    n_fail++;
                    $display("FAIL ordered_gap got %h expected %h", obs_vec(0), exp_vec(0));
                end
            end
        end
        re_i = 1'b1;
        tick();
        re_i = 1'b0;
        n_tests++;
        if (d0_dat !== 8'h80 || d0_valid !== 1'b0 || d0_unf !== 1'b1 || d0_primed !== 1'b0) begin
            n_fail++;
            $display("FAIL underrun got dat=%h valid=%b unf=%b primed=%b expected 80/0/1/0",
                     d0_dat, d0_valid, d0_unf, d0_primed);
        end
    endtask

    task automatic test_read_before_prime();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_tests++;
        if (d0_level !== 10'd0 || d0_primed !== 1'b0 || d0_unf !== 1'b1 || d0_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_keeps_unf got lvl=%0d primed=%b unf=%b empty=%b expected 0/0/1/1",
                     d0_level, d0_primed, d0_unf, d0_empty);
        end
        clr_flags_i = 1'b1;
        tick();
        clr_flags_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            we_i  = 1'b1;
            dat_i = 8'($urandom);
            tick();
        end
        we_i = 1'b0;
        re_i = 1'b1;
        tick();
        re_i = 1'b0;
        n_tests++;
        if (d0_dat !== 8'h80 || d0_valid !== 1'b0 || d0_level !== 10'd10 || d0_unf !== 1'b0) begin
            n_fail++;
            $display("FAIL read_before_prime got dat=%h valid=%b lvl=%0d unf=%b expected 80/0/10/0",
                     d0_dat, d0_valid, d0_level, d0_unf);
        end
        for (int m = 0; m < 2; m++) begin
            n_tests++;
            if (obs_vec(m) !== exp_vec(m)) begin
                n_fail++;
                $display("FAIL read_before_prime_model dut%0d got %h expected %h", m, obs_vec(m), exp_vec(m));
            end
        end
    endtask

    task automatic test_overflow();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 513; i++) begin
            we_i  = 1'b1;
            dat_i = 8'(i % 256);
            tick();
            for (int m = 0; m < 2; m++) begin
                n_tests++;
                if (obs_vec(m) !== exp_vec(m)) begin
                    n_fail++;
                    $display("FAIL overflow_fill dut%0d idx %0d got %h expected %h", m, i, obs_vec(m), exp_vec(m));
                end
            end
        end
        we_i = 1'b0;
        n_tests++;
        if (d0_full !== 1'b1 || d0_level !== 10'd512 || d0_ovf !== 1'b1 ||
            d1_full !== 1'b1 || d1_level !== 10'd512 || d1_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_flags got d0 %b/%0d/%b d1 %b/%0d/%b expected 1/512/1 for both",
                     d0_full, d0_level, d0_ovf, d1_full, d1_level, d1_ovf);
        end
        re_i = 1'b1;
        tick();
        re_i = 1'b0;
        n_tests++;
        if (d0_dat !== 8'h00 || d0_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_first_read got %h/%b expected 00/1", d0_dat, d0_valid);
        end
        n_tests++;
        if (d1_dat !== 8'h01 || d1_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overwrite_first_read got %h/%b expected 01/1", d1_dat, d1_valid);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_tests++;
        if (d0_ovf !== 1'b1 || d1_ovf !== 1'b1 || d0_level !== 10'd0) begin
            n_fail++;
            $display("FAIL flush_keeps_ovf got ovf=%b/%b lvl=%0d expected 1/1/0", d0_ovf, d1_ovf, d0_level);
        end
        for (int i = 0; i < 256; i++) begin
            we_i  = 1'b1;
            dat_i = 8'($urandom);
            tick();
        end
        we_i = 1'b0;
        tick();
        for (int c = 0; c < 2000; c++) begin
            we_i    = 1'b1;
            re_i    = 1'b1;
            dat_i   = 8'($urandom);
            flush_i = (c == 1000);
            tick();
            for (int m = 0; m < 2; m++) begin
                n_tests++;
                if (obs_vec(m) !== exp_vec(m)) begin
                    n_fail++;
                    $display("FAIL b2b dut%0d cyc %0d got %h expected %h", m, c, obs_vec(m), exp_vec(m));
                end
            end
            if (c < 1000) begin
                n_tests++;
                if (d0_level !== 10'd256 || d0_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_level cyc %0d got %0d/%b expected 256/1", c, d0_level, d0_valid);
                end
            end
            if (c == 1000) begin
                n_tests++;
                if (d0_level !== 10'd0 || d0_primed !== 1'b0 || d0_ovf !== 1'b1 || d0_unf !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midrun_flush got lvl=%0d primed=%b ovf=%b unf=%b expected 0/0/1/0",
                             d0_level, d0_primed, d0_ovf, d0_unf);
                end
            end
        end
        flush_i = 1'b0;
        we_i    = 1'b0;
        re_i    = 1'b1;
        k       = 0;
        while (q_size(0) > 0 && k < 600) begin
            tick();
            k++;
        end
        n_tests++;
        if (d0_level !== 10'd0 || d0_primed !== 1'b1 || d0_unf !== 1'b0 || k >= 600) begin
            n_fail++;
            $display("FAIL drain got lvl=%0d primed=%b unf=%b cycles=%0d expected 0/1/0/<600",
                     d0_level, d0_primed, d0_unf, k);
        end
        clr_flags_i = 1'b1;
        tick();
        clr_flags_i = 1'b0;
        re_i        = 1'b0;
        n_tests++;
        if (d0_unf !== 1'b1 || d0_ovf !== 1'b0 || d0_primed !== 1'b0 || d0_valid !== 1'b0 || d0_dat !== 8'h80) begin
            n_fail++;
            $display("FAIL clr_vs_underrun got unf=%b ovf=%b primed=%b valid=%b dat=%h expected 1/0/0/0/80",
                     d0_unf, d0_ovf, d0_primed, d0_valid, d0_dat);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            if (c < 2000) begin
                we_i = ($urandom_range(0, 99) < 70);
                re_i = ($urandom_range(0, 99) < 40);
            end else begin
                we_i = ($urandom_range(0, 99) < 30);
                re_i = ($urandom_range(0, 99) < 70);
            end
            dat_i       = 8'($urandom);
            clr_flags_i = ($urandom_range(0, 99) < 2);
            flush_i     = ($urandom_range(0, 999) < 2);
            tick();
            for (int m = 0; m < 2; m++) begin
                n_tests++;
                if (obs_vec(m) !== exp_vec(m)) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc %0d got %h expected %h", m, c, obs_vec(m), exp_vec(m));
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_prefill();
        test_ordered_read();
        test_read_before_prime();
        test_overflow();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
